// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router control path: FSM state encoding,
// address constants and the per-port select helper.
package router_pkg;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        WAIT_TILL_EMPTY    = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        LOAD_PARITY        = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    localparam logic [1:0] ADDR_INVALID = 2'b11;
    localparam int         NUM_PORTS    = 3;

    // Picks the flag belonging to the addressed output port; the invalid address reads as 0.
    function automatic logic port_sel(input logic [NUM_PORTS-1:0] flags, input logic [1:0] addr);
        logic sel;
        case (addr)
            2'd0:    sel = flags[0];
            2'd1:    sel = flags[1];
            2'd2:    sel = flags[2];
            default: sel = 1'b0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/router_ctrl_fsm.sv
// Packet-flow controller for the 1x3 router (Moore FSM, outputs decoded from state).
// Optional feature: define ROUTER_FSM_WAIT_TIMEOUT_EN to bound WAIT_TILL_EMPTY and add drop_pkt.
module router_ctrl_fsm
    import router_pkg::*;
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    #(parameter int WAIT_TMO = 64)
`endif
(
    input  logic       clk,
    input  logic       reset,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    output logic       drop_pkt,
`endif
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       write_enb_reg,
    output logic       rst_int_reg,
    output logic       busy
);

    state_t                 state_reg, state_next;
    logic [1:0]             addr_reg;
    logic [NUM_PORTS-1:0]   empty_vec;
    logic [NUM_PORTS-1:0]   soft_vec;
    logic                   tgt_empty;
    logic                   tgt_soft_reset;

    assign empty_vec      = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign soft_vec       = {soft_reset_2, soft_reset_1, soft_reset_0};
    assign tgt_empty      = port_sel(empty_vec, addr_reg);
    assign tgt_soft_reset = port_sel(soft_vec, addr_reg);

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    localparam int TMR_W = $clog2(WAIT_TMO + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WAIT_TMO - 1);

    logic [TMR_W-1:0] timer_reg, timer_next;
    logic             drop_reg, drop_next;
    logic             timed_out;

    assign timed_out = (timer_reg == TMR_LAST);
    assign drop_pkt  = drop_reg;
`endif

    always_comb begin
        state_next = state_reg;
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
        drop_next  = 1'b0;
`endif
        // A soft reset on the destination abandons the packet from any active state.
        if (state_reg != DECODE_ADDRESS && tgt_soft_reset) begin
            state_next = DECODE_ADDRESS;
        end else begin
            case (state_reg)
                DECODE_ADDRESS: begin
                    if (pkt_valid && data_in != ADDR_INVALID)
                        state_next = port_sel(empty_vec, data_in) ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
                WAIT_TILL_EMPTY: begin
                    if (tgt_empty) begin
                        state_next = LOAD_FIRST_DATA;
                    end
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
                    else if (timed_out) begin
                        state_next = DECODE_ADDRESS;
                        drop_next  = 1'b1;
                    end
`endif
                end
                LOAD_FIRST_DATA: state_next = LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full)
                        state_next = FIFO_FULL_STATE;
                    else if (!pkt_valid)
                        state_next = LOAD_PARITY;
                end
                FIFO_FULL_STATE: begin
                    if (!fifo_full)
                        state_next = LOAD_AFTER_FULL;
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done)
                        state_next = DECODE_ADDRESS;
                    else if (low_pkt_valid)
                        state_next = LOAD_PARITY;
                    else
                        state_next = LOAD_DATA;
                end
                LOAD_PARITY: state_next = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    state_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                end
                default: state_next = DECODE_ADDRESS;
            endcase
        end
    end

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    // Timer only advances while staying in WAIT_TILL_EMPTY, so entry always starts from zero.
    always_comb begin
        timer_next = '0;
        if (state_reg == WAIT_TILL_EMPTY && state_next == WAIT_TILL_EMPTY)
            timer_next = timer_reg + 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= DECODE_ADDRESS;
            addr_reg  <= 2'd0;
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
            timer_reg <= '0;
            drop_reg  <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            if (state_reg == DECODE_ADDRESS && pkt_valid)
                addr_reg <= data_in;
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
            timer_reg <= timer_next;
            drop_reg  <= drop_next;
`endif
        end
    end

    assign detect_add    = (state_reg == DECODE_ADDRESS);
    assign lfd_state     = (state_reg == LOAD_FIRST_DATA);
    assign ld_state      = (state_reg == LOAD_DATA);
    assign laf_state     = (state_reg == LOAD_AFTER_FULL);
    assign full_state    = (state_reg == FIFO_FULL_STATE);
    assign write_enb_reg = (state_reg == LOAD_DATA) || (state_reg == LOAD_PARITY) ||
                           (state_reg == LOAD_AFTER_FULL);
    assign rst_int_reg   = (state_reg == CHECK_PARITY_ERROR);
    assign busy          = (state_reg != DECODE_ADDRESS) && (state_reg != LOAD_DATA);

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Directed bench for router_ctrl_fsm; the timeout section runs only when
// ROUTER_FSM_WAIT_TIMEOUT_EN is defined.
module tb_router_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       parity_done, low_pkt_valid;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       write_enb_reg, rst_int_reg, busy;
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    logic       drop_pkt;
`endif

    int checks   = 0;
    int failures = 0;

    // Output vector: {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy}
    logic [7:0] outs;
    assign outs = {detect_add, lfd_state, ld_state, laf_state, full_state,
                   write_enb_reg, rst_int_reg, busy};

    localparam logic [7:0] E_DEC  = 8'b1000_0000;
    localparam logic [7:0] E_LFD  = 8'b0100_0001;
    localparam logic [7:0] E_LD   = 8'b0010_0100;
    localparam logic [7:0] E_LAF  = 8'b0001_0101;
    localparam logic [7:0] E_FULL = 8'b0000_1001;
    localparam logic [7:0] E_LP   = 8'b0000_0101;
    localparam logic [7:0] E_CPE  = 8'b0000_0011;
    localparam logic [7:0] E_WAIT = 8'b0000_0001;

    always #5 clk = ~clk;

    router_ctrl_fsm dut (
        .clk           (clk),
        .reset         (reset),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .fifo_empty_0  (fifo_empty_0),
        .fifo_empty_1  (fifo_empty_1),
        .fifo_empty_2  (fifo_empty_2),
        .soft_reset_0  (soft_reset_0),
        .soft_reset_1  (soft_reset_1),
        .soft_reset_2  (soft_reset_2),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
        .drop_pkt      (drop_pkt),
`endif
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .write_enb_reg (write_enb_reg),
        .rst_int_reg   (rst_int_reg),
        .busy          (busy)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance one clock, then sample the Moore outputs 1 time unit after the edge.
    task automatic step_chk(input string tag, input logic [7:0] exp);
        @(posedge clk);
        #1;
        chk(tag, outs, exp);
    endtask

    initial begin
        reset = 1'b1; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
        fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
        parity_done = 1'b0; low_pkt_valid = 1'b0;

        step_chk("reset", E_DEC);
        reset = 1'b0;
        step_chk("idle", E_DEC);

        // Normal packet to FIFO 1: header, 4 payload bytes, then parity.
        pkt_valid = 1'b1; data_in = 2'd1;
        step_chk("pkt1_lfd", E_LFD);
        data_in = 2'd2;
        for (int i = 0; i < 4; i++) step_chk($sformatf("pkt1_ld%0d", i), E_LD);
        pkt_valid = 1'b0;
        step_chk("pkt1_lp", E_LP);
        step_chk("pkt1_cpe", E_CPE);
        step_chk("pkt1_dec", E_DEC);

        // Busy destination: FIFO 2 not empty for 10 cycles.
        fifo_empty_2 = 1'b0; pkt_valid = 1'b1; data_in = 2'd2;
        step_chk("wait_entry", E_WAIT);
        data_in = 2'd0;
        for (int i = 0; i < 9; i++) step_chk($sformatf("wait_hold%0d", i), E_WAIT);
        fifo_empty_2 = 1'b1;
        step_chk("wait_lfd", E_LFD);
        step_chk("wait_ld", E_LD);

        // Full stall for 3 cycles, then parity_done finishes the packet.
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) step_chk($sformatf("stall_full%0d", i), E_FULL);
        fifo_full = 1'b0;
        step_chk("stall_laf", E_LAF);
        parity_done = 1'b1;
        step_chk("stall_done_dec", E_DEC);
        parity_done = 1'b0;

        // Packet to FIFO 0: full beats !pkt_valid, LAF loops back, CPE re-stalls.
        pkt_valid = 1'b1; data_in = 2'd0;
        step_chk("p0_lfd", E_LFD);
        step_chk("p0_ld", E_LD);
        fifo_full = 1'b1; pkt_valid = 1'b0;
        step_chk("p0_full_wins", E_FULL);
        fifo_full = 1'b0;
        step_chk("p0_laf", E_LAF);
        step_chk("p0_laf_to_ld", E_LD);
        step_chk("p0_lp", E_LP);
        fifo_full = 1'b1;
        step_chk("p0_cpe", E_CPE);
        step_chk("p0_cpe_full", E_FULL);
        fifo_full = 1'b0;
        step_chk("p0_laf2", E_LAF);
        low_pkt_valid = 1'b1;
        step_chk("p0_laf_low_lp", E_LP);
        low_pkt_valid = 1'b0;
        step_chk("p0_cpe2", E_CPE);
        step_chk("p0_dec", E_DEC);

        // Invalid address 3 is ignored.
        pkt_valid = 1'b1; data_in = 2'd3;
        step_chk("addr3_a", E_DEC);
        step_chk("addr3_b", E_DEC);

        // Soft reset: only the addressed FIFO's soft reset aborts.
        data_in = 2'd0;
        step_chk("sr_lfd", E_LFD);
        step_chk("sr_ld", E_LD);
        soft_reset_1 = 1'b1;
        step_chk("sr_other_ignored", E_LD);
        soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
        step_chk("sr_abort", E_DEC);
        soft_reset_0 = 1'b0; pkt_valid = 1'b0;
        step_chk("sr_idle", E_DEC);

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
        // Timeout: 64 cycles in WAIT_TILL_EMPTY, then abort with a one-cycle drop pulse.
        fifo_empty_1 = 1'b0; pkt_valid = 1'b1; data_in = 2'd1;
        step_chk("tmo_entry", E_WAIT);
        pkt_valid = 1'b0;
        for (int i = 1; i < 64; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("tmo_wait%0d", i), {outs[7:1], drop_pkt}, {E_WAIT[7:1], 1'b0});
        end
        @(posedge clk);
        #1;
        chk("tmo_drop", {outs[7:1], drop_pkt}, {E_DEC[7:1], 1'b1});
        @(posedge clk);
        #1;
        chk("tmo_drop_end", {outs[7:1], drop_pkt}, {E_DEC[7:1], 1'b0});
        fifo_empty_1 = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
